ysyx_23060077_ifu: RTL and testbench
====================================

// Module: ysyx_23060077_ifu
// PURPOSE
//  Instruction fetch unit: producer side of the instruction interface consumed by the decode stage.
//  Holds the PC and issues one AXI4-Lite read per instruction (single outstanding request).
//  Presents {inst, inst_pc, fetch_err} to decode with a valid/ready handshake.
//  Accepts PC redirects from execute/trap logic.
// PARAMETERS
//  RESET_PC  32'h3000_0000  PC of the first fetch after reset
// PORTS
//  clk             in   1   clock; all state updates on its rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  redirect_valid  in   1   replace the PC this cycle (branch/jump/trap/mret)
//  redirect_pc     in   32  new PC
//  inst_valid      out  1   inst/inst_pc/fetch_err valid toward decode
//  inst_ready      in   1   decode accepts the instruction
//  inst            out  32  fetched instruction word (`INST_WIDTH)
//  inst_pc         out  32  PC of inst
//  fetch_err       out  1   bus returned rresp != 2'b00 for this fetch
//  araddr          out  32  read address = {pc[31:2],2'b00}
//  arvalid         out  1   read address valid
//  arready         in   1   read address accepted
//  rdata           in   32  read data
//  rresp           in   2   read response
//  rvalid          in   1   read data valid
//  rready          out  1   read data accept
// BEHAVIOUR
//  Reset: pc=RESET_PC; state=IDLE; arvalid=rready=inst_valid=fetch_err=0; inst=inst_pc=0; kill=0.
//  FSM IDLE->ADDR->DATA->HOLD->ADDR; all outputs registered or decoded from state only.
//   IDLE: exits to ADDR one cycle after reset release.
//   ADDR: arvalid=1; araddr held stable until arvalid&arready, then DATA.
//   DATA: rready=1. On rvalid: if kill -> discard, clear kill, go ADDR at current pc.
//         Otherwise latch inst=rdata, inst_pc=pc, fetch_err=|rresp; go HOLD.
//   HOLD: inst_valid=1; outputs stable until inst_ready. On inst_ready: pc=pc+4, go ADDR.
//  Redirect handling (redirect_valid in any state):
//   - IDLE/HOLD: pc=redirect_pc; go ADDR; inst_valid drops next cycle; the held instruction is dropped.
//   - ADDR/DATA: arvalid is never withdrawn. pc=redirect_pc and kill=1, so the in-flight response is discarded.
//   - Redirect on the same cycle as the rvalid that completes a killed/unkilled fetch:
//     data discarded, next ADDR uses redirect_pc.
//   - Redirect and inst_ready on the same cycle: redirect wins (pc=redirect_pc, not pc+4).
//   - Repeated redirects before refetch: last one wins.
//  pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000). redirect_pc[1:0] is not checked here.
//  Minimum latency: inst_ready handshake at T, with immediate arready/rvalid, gives next inst_valid at T+3.
//  fetch_err instructions are delivered normally; decode/exception logic handles them.
//  Async reset mid-transaction returns to the reset state. The outstanding bus beat is the interconnect's concern.
// CONFIGURATION
//  YSYX_23060077_IFU_PERF_EN defined:
//   - Adds outputs perf_fetch_cnt[31:0] (incremented on each inst_valid&inst_ready) and
//     perf_stall_cnt[31:0] (incremented each cycle in ADDR or DATA).
//   - Both counters reset to 0 and wrap at 2^32.
//  Undefined: ports and counters absent; fetch behaviour identical.
// STRUCTURE
//  ysyx_23060077_define.v: `IFU_IDLE/`IFU_ADDR/`IFU_DATA/`IFU_HOLD 2-bit encodings,
//   `INST_WIDTH, `ADDR_WIDTH, `RESP_OKAY.
//  One sub-module: ysyx_23060077_ifu_pc (PC register, kill flag, next-pc mux: redirect > +4 > hold).
// TESTING
//  1 Reset release, arready/rvalid immediate, rdata=0x00000013:
//    araddr=0x3000_0000; inst_valid at cycle 3; inst_pc=0x3000_0000; next araddr=0x3000_0004.
//  2 inst_ready low for 5 cycles in HOLD: inst/inst_pc stable; no new arvalid; then one handshake, one new fetch.
//  3 redirect_valid (0x8000_0100) while in DATA, rvalid 2 cycles later:
//    that data never appears on inst; next araddr=0x8000_0100.
//  4 redirect_valid and inst_ready on the same cycle in HOLD (pc 0x3000_0010, redirect 0x3000_0040):
//    next araddr=0x3000_0040.
//  5 rresp=2'b10 on a fetch: inst_valid with fetch_err=1, inst=rdata; the next fetch has fetch_err=0.
//  6 Redirect to 0xFFFF_FFFC and accept: next araddr=0x0000_0000.
//    With PERF_EN: perf_fetch_cnt matches the number of handshakes; stall cycles are counted with arready delayed 3 cycles.

Source files
------------

// File: rtl/ysyx_23060077_ifu_pkg.sv
// Shared types and constants for the ysyx_23060077 instruction fetch unit.
// State encodings, bus widths and the OKAY response code live here.
package ysyx_23060077_ifu_pkg;

  localparam int INST_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'b00,
    IFU_ADDR = 2'b01,
    IFU_DATA = 2'b10,
    IFU_HOLD = 2'b11
  } ifu_state_t;

  // Instructions are word aligned; the low address bits never reach the bus.
  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
    return addr & ~(ADDR_WIDTH'(3));
  endfunction

endpackage

// File: rtl/ysyx_23060077_ifu_pc.sv
// PC register, kill flag and next-PC selection for the fetch unit.
// Priority of the next-PC mux: redirect, then sequential advance, then hold.
module ysyx_23060077_ifu_pc
  import ysyx_23060077_ifu_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h3000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  advance,
  input  logic                  set_kill,
  input  logic                  clr_kill,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_next,
  output logic                  kill
);

  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (advance) begin
      pc_next = pc + ADDR_WIDTH'(4);
    end
  end

  // kill marks an in-flight read whose data belongs to a PC we no longer want.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= RESET_PC;
      kill <= 1'b0;
    end else begin
      pc <= pc_next;
      if (set_kill) begin
        kill <= 1'b1;
      end else if (clr_kill) begin
        kill <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ysyx_23060077_ifu.sv
// Instruction fetch unit: one outstanding AXI4-Lite read per instruction, valid/ready to decode.
// Optional performance counters are built when YSYX_23060077_IFU_PERF_EN is defined.
module ysyx_23060077_ifu
  import ysyx_23060077_ifu_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h3000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  fetch_err,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [INST_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
`ifdef YSYX_23060077_IFU_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  ifu_state_t            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  kill;
  logic                  advance;
  logic                  set_kill;
  logic                  clr_kill;
  logic                  r_done;

  assign arvalid    = (state == IFU_ADDR);
  assign rready     = (state == IFU_DATA);
  assign inst_valid = (state == IFU_HOLD);

  assign r_done  = (state == IFU_DATA) && rvalid;
  assign advance = (state == IFU_HOLD) && inst_ready;
  // A redirect that lands on the completing rvalid needs no kill: that data is dropped right away.
  assign set_kill = redirect_valid && ((state == IFU_ADDR) || ((state == IFU_DATA) && !rvalid));
  assign clr_kill = r_done;

  ysyx_23060077_ifu_pc #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (advance),
    .set_kill       (set_kill),
    .clr_kill       (clr_kill),
    .pc             (pc),
    .pc_next        (pc_next),
    .kill           (kill)
  );

  // araddr is captured on entry to ADDR so a redirect cannot disturb a pending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IFU_IDLE;
      araddr    <= '0;
      inst      <= '0;
      inst_pc   <= '0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        IFU_IDLE: begin
          state  <= IFU_ADDR;
          araddr <= word_align(pc_next);
        end
        IFU_ADDR: begin
          if (arready) begin
            state <= IFU_DATA;
          end
        end
        IFU_DATA: begin
          if (rvalid) begin
            if (kill || redirect_valid) begin
              state  <= IFU_ADDR;
              araddr <= word_align(pc_next);
            end else begin
              inst      <= rdata;
              inst_pc   <= pc;
              fetch_err <= (rresp != RESP_OKAY);
              state     <= IFU_HOLD;
            end
          end
        end
        IFU_HOLD: begin
          if (redirect_valid || inst_ready) begin
            state  <= IFU_ADDR;
            araddr <= word_align(pc_next);
          end
        end
        default: state <= IFU_IDLE;
      endcase
    end
  end

`ifdef YSYX_23060077_IFU_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (inst_valid && inst_ready) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if ((state == IFU_ADDR) || (state == IFU_DATA)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`else
  // Counters are compiled out; the fetch path is unaffected.
`endif

endmodule

// File: tb/tb_ysyx_23060077_ifu.sv
// Self-checking bench for ysyx_23060077_ifu: a table of sequential fetches plus
// hand-written redirect, wrap and reset sequences against a small AXI4-Lite responder.
module tb_ysyx_23060077_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
`ifdef YSYX_23060077_IFU_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  ysyx_23060077_ifu #(
    .RESET_PC(32'h3000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .fetch_err      (fetch_err),
    .araddr         (araddr),
    .arvalid        (arvalid),
    .arready        (arready),
    .rdata          (rdata),
    .rresp          (rresp),
    .rvalid         (rvalid),
    .rready         (rready)
`ifdef YSYX_23060077_IFU_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        err;
    int          stall;
    bit          accept;
  } vec_t;

  vec_t        vecs[5];
  int          passed = 0;
  int          total = 0;
  int          ar_delay = 0;
  int          r_delay = 0;
  int          hs_count = 0;
  logic [31:0] err_addr = 32'h3000_000C;
  logic [31:0] ar_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h3000_0000) ? 32'h0000_0013 : (a ^ 32'h1357_9BDF);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic wait_valid(input int limit, output int cyc);
    cyc = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (inst_valid === 1'b1) begin
        cyc = i;
        return;
      end
    end
    total++;
    $display("FAIL wait_valid: no inst_valid within %0d cycles", limit);
  endtask

  task automatic wait_rready(input int limit);
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (rready === 1'b1) return;
    end
    total++;
    $display("FAIL wait_rready: no rready within %0d cycles", limit);
  endtask

  task automatic handshake();
    inst_ready = 1'b1;
    hs_count++;
    @(negedge clk);
    inst_ready = 1'b0;
  endtask

  // Memory-like slave: arready after ar_delay cycles, rvalid r_delay cycles after the address.
  initial begin : responder
    bit          pending;
    int          cnt;
    logic [31:0] pend_addr;
    pending = 0;
    cnt = 0;
    pend_addr = '0;
    arready = 1'b0;
    rvalid = 1'b0;
    rdata = '0;
    rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        arready = 1'b0;
        rvalid = 1'b0;
        pending = 0;
        cnt = 0;
      end else begin
        if (rvalid) begin
          rvalid = 1'b0;
          pending = 0;
          cnt = 0;
        end
        if (arready) begin
          arready = 1'b0;
          pending = 1;
          cnt = 0;
        end
        if (pending) begin
          if (cnt >= r_delay) begin
            rvalid = 1'b1;
            rdata = mem_word(pend_addr);
            rresp = (pend_addr == err_addr) ? 2'b10 : 2'b00;
          end else begin
            cnt++;
          end
        end else if (arvalid) begin
          if (cnt >= ar_delay) begin
            arready = 1'b1;
            pend_addr = araddr;
            ar_log.push_back(araddr);
          end else begin
            cnt++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    int  cyc;
    int  n_ar;
    bit  stable;
`ifdef YSYX_23060077_IFU_PERF_EN
    logic [31:0] s0;
`endif
    vecs[0] = '{32'h3000_0000, 1'b0, 0, 1'b1};
    vecs[1] = '{32'h3000_0004, 1'b0, 5, 1'b1};
    vecs[2] = '{32'h3000_0008, 1'b0, 0, 1'b1};
    vecs[3] = '{32'h3000_000C, 1'b1, 2, 1'b1};
    vecs[4] = '{32'h3000_0010, 1'b0, 0, 1'b0};

    redirect_valid = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_fetch_err", fetch_err, 0);
    rst_n = 1'b1;

    n_ar = 0;
    for (int i = 0; i < 5; i++) begin
      wait_valid(20, cyc);
      check($sformatf("v%0d_latency", i), (i == 0) ? cyc : cyc + 1, 3);
      check($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].pc);
      check($sformatf("v%0d_inst", i), inst, mem_word(vecs[i].pc));
      check($sformatf("v%0d_fetch_err", i), fetch_err, vecs[i].err);
      check($sformatf("v%0d_ar_count", i), 32'(ar_log.size()), 32'(n_ar + 1));
      check($sformatf("v%0d_araddr", i), ar_log[$], vecs[i].pc);
      stable = 1;
      for (int k = 0; k < vecs[i].stall; k++) begin
        @(negedge clk);
        if (inst !== mem_word(vecs[i].pc) || inst_pc !== vecs[i].pc ||
            inst_valid !== 1'b1 || arvalid !== 1'b0) stable = 0;
      end
      if (vecs[i].stall > 0) check($sformatf("v%0d_hold_stable", i), 32'(stable), 1);
      if (vecs[i].accept) begin
        n_ar = ar_log.size();
        handshake();
      end
    end

    // Redirect and inst_ready together in HOLD: redirect wins.
    redirect_pc = 32'h3000_0040;
    redirect_valid = 1'b1;
    inst_ready = 1'b1;
    hs_count++;
    @(negedge clk);
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    check("redir_ready_drop", inst_valid, 0);
    wait_valid(20, cyc);
    check("redir_ready_pc", inst_pc, 32'h3000_0040);
    check("redir_ready_araddr", ar_log[$], 32'h3000_0040);
    check("redir_ready_inst", inst, mem_word(32'h3000_0040));

    // Redirect while the read is in DATA; the stale word must never reach decode.
    r_delay = 2;
    handshake();
    wait_rready(20);
    redirect_pc = 32'h8000_0100;
    redirect_valid = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("kill_still_data", rready, 1);
    wait_valid(30, cyc);
    r_delay = 0;
    check("kill_inst_pc", inst_pc, 32'h8000_0100);
    check("kill_inst", inst, mem_word(32'h8000_0100));
    check("kill_araddr", ar_log[$], 32'h8000_0100);
    check("kill_stale_addr", ar_log[$-1], 32'h3000_0044);

    // Redirect from HOLD to the top word, then wrap.
    redirect_pc = 32'hFFFF_FFFC;
    redirect_valid = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_valid(20, cyc);
    check("wrap_top_pc", inst_pc, 32'hFFFF_FFFC);
    handshake();
    wait_valid(20, cyc);
    check("wrap_zero_pc", inst_pc, 32'h0000_0000);
    check("wrap_araddr", ar_log[$], 32'h0000_0000);

    // Redirect while arvalid waits on a slow arready: araddr must not move.
    ar_delay = 3;
`ifdef YSYX_23060077_IFU_PERF_EN
    s0 = perf_stall_cnt;
`endif
    handshake();
    check("addr_araddr", araddr, 32'h0000_0004);
    redirect_pc = 32'h3000_0100;
    redirect_valid = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("addr_araddr_stable", araddr, 32'h0000_0004);
    check("addr_arvalid_held", arvalid, 1);
    wait_valid(40, cyc);
    check("addr_redir_pc", inst_pc, 32'h3000_0100);
    check("addr_redir_araddr", ar_log[$], 32'h3000_0100);
    check("addr_first_araddr", ar_log[$-1], 32'h0000_0004);
`ifdef YSYX_23060077_IFU_PERF_EN
    check("perf_stall_delta", perf_stall_cnt - s0, 32'd10);
    check("perf_fetch_cnt", perf_fetch_cnt, 32'(hs_count));
`endif
    ar_delay = 0;

    // Asynchronous reset while a read is in DATA.
    handshake();
    wait_rready(20);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rready", rready, 0);
    check("arst_inst_pc", inst_pc, 0);
    check("arst_arvalid", arvalid, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_valid(20, cyc);
    check("arst_latency", cyc, 3);
    check("arst_refetch_pc", inst_pc, 32'h3000_0000);
    check("arst_refetch_inst", inst, 32'h0000_0013);
`ifdef YSYX_23060077_IFU_PERF_EN
    check("perf_fetch_after_rst", perf_fetch_cnt, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
